// File: rtl/ripple_rd_pkg.sv
// Shared constants and FSM encoding for the ripple counter reader.
package ripple_rd_pkg;

  localparam int unsigned DefCw           = 4;
  localparam int unsigned DefAccW         = 16;
  localparam int unsigned DefStableCycles = 2;

  // Width of the stability counter; covers STABLE_CYCLES up to 7.
  localparam int unsigned StabW = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_STABLE = 2'd1,
    PRESENT     = 2'd2
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;

  // Shift the asynchronous input through two stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/ripple_count_reader.sv
// Reads a free-running ripple counter, accumulates its counts into a wide
// total and reports snapshots of that total over a valid/ready handshake.
module ripple_count_reader
  import ripple_rd_pkg::*;
#(
  parameter int unsigned CW            = DefCw,
  parameter int unsigned ACC_W         = DefAccW,
  parameter int unsigned STABLE_CYCLES = DefStableCycles
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [CW-1:0]    A,
  input  logic             Sample_Req,
  input  logic             Ready,
  output logic             Valid,
  output logic [ACC_W-1:0] Count_Out,
  output logic [ACC_W-1:0] Delta_Out,
  output logic             Overflow
);

  localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES);

  logic [CW-1:0]    sync2;
  logic [CW-1:0]    sync2_d_q;
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  logic [CW-1:0]    last_val_q, last_val_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [ACC_W-1:0] last_report_q, last_report_d;
  logic [ACC_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] delta_q, delta_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;

  logic             changed;
  logic             stable;
  logic             accept;
  logic [CW-1:0]    step;
  logic [ACC_W:0]   sum;

  sync_2ff #(
    .Width (CW)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (Reset),
    .d_i   (A),
    .q_o   (sync2)
  );

  // Stability tracking and accumulation of counter deltas.
  always_comb begin
    changed = (sync2 != sync2_d_q);
    stab_cnt_d = stab_cnt_q;
    if (changed) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q < StabMax) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
    // The counter only resets on the edge after a change, so also require no
    // change this cycle; otherwise a single-cycle ripple value could slip in.
    stable = (stab_cnt_q == StabMax) && !changed;
    accept = stable && (sync2 != last_val_q);
    step   = sync2 - last_val_q;
    sum    = {1'b0, total_q} + (ACC_W + 1)'(step);

    total_d    = total_q;
    last_val_d = last_val_q;
    ovf_d      = ovf_q;
    if (accept) begin
      total_d    = sum[ACC_W-1:0];
      last_val_d = sync2;
      ovf_d      = ovf_q | sum[ACC_W];
    end
  end

  // Report FSM; the snapshot includes any accumulation on the same edge.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    delta_d       = delta_q;
    last_report_d = last_report_q;
    unique case (state_q)
      IDLE: begin
        if (Sample_Req) state_d = WAIT_STABLE;
      end
      WAIT_STABLE: begin
        if (stable) begin
          count_d       = total_d;
          delta_d       = total_d - last_report_q;
          last_report_d = total_d;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        if (Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync2_d_q     <= '0;
      stab_cnt_q    <= '0;
      last_val_q    <= '0;
      total_q       <= '0;
      last_report_q <= '0;
      count_q       <= '0;
      delta_q       <= '0;
      ovf_q         <= 1'b0;
      state_q       <= IDLE;
    end else begin
      sync2_d_q     <= sync2;
      stab_cnt_q    <= stab_cnt_d;
      last_val_q    <= last_val_d;
      total_q       <= total_d;
      last_report_q <= last_report_d;
      count_q       <= count_d;
      delta_q       <= delta_d;
      ovf_q         <= ovf_d;
      state_q       <= state_d;
    end
  end

  assign Valid     = (state_q == PRESENT);
  assign Count_Out = count_q;
  assign Delta_Out = delta_q;
  assign Overflow  = ovf_q;

endmodule
